run_controller: RTL and testbench

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_controller.sv | 155 +++++++++++++++
 tb/tb_run_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// Timed motor run controller: BCD countdown driven by a one-second prescaler,
// with a FWD/GAP/REV/GAP drive cycle and PWM-gated motor lines.
module run_controller #(
  parameter int TICK_DIV  = 100,
  parameter int PHASE_SEC = 5
) (
  input  logic       sysclk,
  input  logic       INIT,
  input  logic       Start,
  input  logic       Pause,
  input  logic [3:0] TValue0,
  input  logic [3:0] TValue1,
  input  logic [3:0] TValue2,
  input  logic [5:0] Speed,
  output logic [3:0] RValue0,
  output logic [3:0] RValue1,
  output logic [3:0] RValue2,
  output logic       MotorFwd,
  output logic       MotorRev,
  output logic       Running,
  output logic       Done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (PHASE_SEC > 1) ? $clog2(PHASE_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(PHASE_SEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;
  typedef enum logic [1:0] {PH_FWD, PH_GAP1, PH_REV, PH_GAP2} phase_t;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Three-digit BCD decrement with borrow; never applied to 000.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] d0, d1, d2;
    {d2, d1, d0} = v;
    if (d0 != 4'd0) begin
      d0 = d0 - 4'd1;
    end else begin
      d0 = 4'd9;
      if (d1 != 4'd0) begin
        d1 = d1 - 4'd1;
      end else begin
        d1 = 4'd9;
        d2 = d2 - 4'd1;
      end
    end
    return {d2, d1, d0};
  endfunction

  state_t        state, n_state;
  phase_t        phase, n_phase;
  logic [11:0]   rem, n_rem;
  logic [PW-1:0] presc, n_presc;
  logic [CW-1:0] pcnt, n_pcnt;
  logic [CW-1:0] phase_last;
  logic [5:0]    pwm, n_pwm;
  logic [5:0]    speed_q, n_speed;
  logic          start_d, pause_d;
  logic          start_rise, pause_rise, tick, n_drive;
  logic [11:0]   load_val;

  assign start_rise = Start & ~start_d;
  assign pause_rise = Pause & ~pause_d;
  assign load_val   = {clamp_digit(TValue2), clamp_digit(TValue1), clamp_digit(TValue0)};
  assign phase_last = (phase == PH_FWD || phase == PH_REV) ? DRIVE_LAST : '0;
  assign tick       = (state == S_RUN) && (presc == PRESC_LAST);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    n_state = state;
    n_phase = phase;
    n_rem   = rem;
    n_presc = presc;
    n_pcnt  = pcnt;
    n_pwm   = pwm;
    n_speed = speed_q;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_rise) begin
          n_rem   = load_val;
          n_speed = Speed;
          n_presc = '0;
          n_phase = PH_FWD;
          n_pcnt  = '0;
          n_pwm   = '0;
          n_state = (load_val == 12'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        n_pwm   = pwm + 6'd1;
        n_presc = tick ? '0 : presc + 1'b1;
        if (pause_rise) n_state = S_PAUSE;
        if (tick) begin
          n_rem = bcd_dec(rem);
          if (pcnt == phase_last) begin
            n_phase = phase_t'(phase + 2'd1);
            n_pcnt  = '0;
          end else begin
            n_pcnt = pcnt + 1'b1;
          end
          // Reaching zero outranks a simultaneous pause request.
          if (n_rem == 12'd0) n_state = S_DONE;
        end
      end
      S_PAUSE: begin
        if (pause_rise) n_state = S_RUN;
      end
      default: n_state = S_IDLE;
    endcase
  end

  assign n_drive = (n_pwm < n_speed);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge sysclk or posedge INIT) begin
    if (INIT) begin
      state    <= S_IDLE;
      phase    <= PH_FWD;
      rem      <= '0;
      presc    <= '0;
      pcnt     <= '0;
      pwm      <= '0;
      speed_q  <= '0;
      start_d  <= 1'b0;
      pause_d  <= 1'b0;
      MotorFwd <= 1'b0;
      MotorRev <= 1'b0;
      Running  <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state    <= n_state;
      phase    <= n_phase;
      rem      <= n_rem;
      presc    <= n_presc;
      pcnt     <= n_pcnt;
      pwm      <= n_pwm;
      speed_q  <= n_speed;
      start_d  <= Start;
      pause_d  <= Pause;
      MotorFwd <= (n_state == S_RUN) && (n_phase == PH_FWD) && n_drive;
      MotorRev <= (n_state == S_RUN) && (n_phase == PH_REV) && n_drive;
      Running  <= (n_state == S_RUN);
      Done     <= (n_state == S_DONE);
    end
  end

  assign {RValue2, RValue1, RValue0} = rem;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: directed vector table, multi-cycle
// corner sequences, and randomized stimulus against an arithmetic reference model.
module tb_run_controller;
  localparam int TD = 4;
  localparam int PS = 2;

  logic       sysclk = 1'b0;
  logic       INIT, Start, Pause;
  logic [3:0] TValue0, TValue1, TValue2;
  logic [5:0] Speed;
  logic [3:0] RValue0, RValue1, RValue2;
  logic       MotorFwd, MotorRev, Running, Done;

  int n_checks = 0;
  int n_errors = 0;

  run_controller #(.TICK_DIV(TD), .PHASE_SEC(PS)) dut (
    .sysclk(sysclk), .INIT(INIT), .Start(Start), .Pause(Pause),
    .TValue0(TValue0), .TValue1(TValue1), .TValue2(TValue2), .Speed(Speed),
    .RValue0(RValue0), .RValue1(RValue1), .RValue2(RValue2),
    .MotorFwd(MotorFwd), .MotorRev(MotorRev), .Running(Running), .Done(Done)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining seconds as an integer, time in RUN as a cycle age.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_mode, m_rem, m_speed, m_age;
  bit m_ps, m_pp;

  function automatic int clampd(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_rem = 0; m_speed = 0; m_age = 0; m_ps = 0; m_pp = 0;
  endtask

  task automatic model_step();
    bit srise, prise, tick;
    srise = Start && !m_ps;
    prise = Pause && !m_pp;
    m_ps = Start;
    m_pp = Pause;
    case (m_mode)
      M_IDLE, M_DONE: if (srise) begin
        m_rem   = 100 * clampd(TValue2) + 10 * clampd(TValue1) + clampd(TValue0);
        m_speed = int'(Speed);
        m_age   = 0;
        m_mode  = (m_rem == 0) ? M_DONE : M_RUN;
      end
      M_RUN: begin
        tick = (m_age % TD) == TD - 1;
        m_age++;
        if (tick) m_rem--;
        if (tick && m_rem == 0) m_mode = M_DONE;
        else if (prise) m_mode = M_PAUSE;
      end
      M_PAUSE: if (prise) m_mode = M_RUN;
      default: ;
    endcase
  endtask

  function automatic logic [15:0] model_vec();
    int pos;
    logic run, fwd, rev, drv;
    run = (m_mode == M_RUN);
    pos = (m_age / TD) % (2 * PS + 2);
    drv = (m_age % 64) < m_speed;
    fwd = run && (pos < PS) && drv;
    rev = run && (pos > PS) && (pos < 2 * PS + 1) && drv;
    return {4'(m_rem / 100), 4'((m_rem / 10) % 10), 4'(m_rem % 10),
            run, (m_mode == M_DONE), fwd, rev};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {RValue2, RValue1, RValue0, Running, Done, MotorFwd, MotorRev};
  endfunction

  task automatic cycle();
    @(posedge sysclk);
    if (INIT) model_reset();
    else model_step();
    #1;
    check("model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  // Asynchronous reset pulse landing mid-cycle; outputs must clear before the next edge.
  task automatic do_init();
    #2 INIT = 1'b1;
    #1 model_reset();
    check("init_async", 32'(dut_vec()), 32'd0);
    cycle();
    INIT = 1'b0;
  endtask

  typedef struct {
    bit         start, pause;
    logic [3:0] t2, t1, t0;
    logic [5:0] speed;
    int         cyc;
    logic [11:0] r;
    bit         run, done, fwd, rev;
  } vec_t;

  function automatic vec_t mk(bit s, bit p, logic [3:0] t2, logic [3:0] t1, logic [3:0] t0,
                              logic [5:0] sp, int cyc, logic [11:0] r,
                              bit run, bit done, bit fwd, bit rev);
    vec_t v;
    v.start = s; v.pause = p; v.t2 = t2; v.t1 = t1; v.t0 = t0; v.speed = sp; v.cyc = cyc;
    v.r = r; v.run = run; v.done = done; v.fwd = fwd; v.rev = rev;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    int n, bad, nf, nr;

    tbl[0]  = mk(1, 0, 0, 1, 0, 63,  1, 12'h010, 1, 0, 1, 0);
    tbl[1]  = mk(0, 0, 0, 1, 0, 63,  4, 12'h009, 1, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 1, 0, 63,  4, 12'h008, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 0, 63,  4, 12'h007, 1, 0, 0, 1);
    tbl[4]  = mk(0, 1, 0, 1, 0, 63,  1, 12'h007, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 1, 0, 63, 10, 12'h007, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 1, 0, 63,  1, 12'h007, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 1, 0, 63,  1, 12'h007, 1, 0, 0, 1);
    tbl[8]  = mk(0, 0, 0, 1, 0, 63,  3, 12'h006, 1, 0, 0, 1);
    tbl[9]  = mk(0, 0, 0, 1, 0, 63, 24, 12'h000, 0, 1, 0, 0);
    tbl[10] = mk(0, 0, 0, 1, 0, 63,  5, 12'h000, 0, 1, 0, 0);
    tbl[11] = mk(0, 1, 0, 1, 0, 63,  1, 12'h000, 0, 1, 0, 0);
    tbl[12] = mk(1, 0, 1, 0, 0, 10,  1, 12'h100, 1, 0, 1, 0);
    tbl[13] = mk(0, 0, 1, 0, 0, 10,  4, 12'h099, 1, 0, 1, 0);
    tbl[14] = mk(0, 0, 1, 0, 0, 10,  8, 12'h097, 1, 0, 0, 0);
    tbl[15] = mk(0, 1, 1, 0, 0, 10,  1, 12'h097, 0, 0, 0, 0);
    tbl[16] = mk(1, 0, 1, 0, 0, 10,  1, 12'h097, 0, 0, 0, 0);

    INIT = 1'b1; Start = 1'b0; Pause = 1'b0;
    TValue0 = '0; TValue1 = '0; TValue2 = '0; Speed = '0;
    model_reset();
    @(posedge sysclk);
    #1 check("reset", 32'(dut_vec()), 32'd0);
    INIT = 1'b0;

    for (int i = 0; i < 17; i++) begin
      Start = tbl[i].start; Pause = tbl[i].pause;
      TValue2 = tbl[i].t2; TValue1 = tbl[i].t1; TValue0 = tbl[i].t0; Speed = tbl[i].speed;
      repeat (tbl[i].cyc) cycle();
      check($sformatf("vec%0d", i), 32'(dut_vec()),
            32'({tbl[i].r, tbl[i].run, tbl[i].done, tbl[i].fwd, tbl[i].rev}));
    end

    // Reset during PAUSE with Start held high: the held level acts as a rise afterwards.
    TValue0 = 4'd9; TValue1 = 4'd15; TValue2 = 4'd15; Speed = 6'd63;
    do_init();
    cycle();
    check("clamp_999", 32'(dut_vec()), 32'({12'h999, 4'b1010}));
    Start = 1'b0;
    repeat (5) cycle();
    check("pre_init_run", 32'(Running), 32'd1);
    do_init();

    // Zero set time goes straight to DONE.
    TValue0 = 4'd0; TValue1 = 4'd0; TValue2 = 4'd0; Start = 1'b1;
    cycle();
    check("zero_done", 32'(dut_vec()), 32'({12'h000, 4'b0100}));
    Start = 1'b0;
    cycle();

    // Start and Pause together in DONE: Start wins.
    TValue0 = 4'd2; Start = 1'b1; Pause = 1'b1;
    cycle();
    check("start_wins", 32'({RValue2, RValue1, RValue0, Running}), 32'({12'h002, 1'b1}));
    Start = 1'b0; Pause = 1'b0;
    repeat (3) cycle();
    Pause = 1'b1;
    cycle();
    check("tick_and_pause", 32'({RValue2, RValue1, RValue0, Running, Done}), 32'({12'h001, 2'b00}));
    Pause = 1'b0; cycle();
    Pause = 1'b1; cycle();
    check("resume", 32'(Running), 32'd1);
    Pause = 1'b0;
    repeat (3) cycle();
    Pause = 1'b1;
    cycle();
    check("done_beats_pause", 32'({RValue2, RValue1, RValue0, Running, Done}), 32'({12'h000, 2'b01}));
    Pause = 1'b0;

    // 010 run: Done 40 cycles after the Start edge.
    TValue0 = 4'd0; TValue1 = 4'd1; TValue2 = 4'd0; Start = 1'b1;
    cycle();
    Start = 1'b0;
    n = 0;
    while (Done !== 1'b1 && n < 100) begin cycle(); n++; end
    check("done_latency", 32'(n), 32'd40);

    // Same run with a pause after two ticks: 51 cycles spent paused.
    Start = 1'b1; cycle(); Start = 1'b0;
    repeat (8) cycle();
    Pause = 1'b1; cycle();
    bad = 0;
    repeat (49) begin
      cycle();
      if ({RValue2, RValue1, RValue0} !== 12'h008 || MotorFwd || MotorRev || Running) bad++;
    end
    check("pause_frozen", 32'(bad), 32'd0);
    Pause = 1'b0; cycle();
    Pause = 1'b1; cycle();
    Pause = 1'b0;
    n = 60;
    while (Done !== 1'b1 && n < 200) begin cycle(); n++; end
    check("pause_latency", 32'(n), 32'd91);

    // Speed 0: countdown proceeds, motors never drive.
    TValue1 = 4'd0; TValue0 = 4'd5; Speed = 6'd0; Start = 1'b1;
    cycle(); Start = 1'b0;
    n = 0; bad = 0;
    while (Done !== 1'b1 && n < 100) begin
      cycle(); n++;
      if (MotorFwd || MotorRev) bad++;
    end
    check("speed0_latency", 32'(n), 32'd20);
    check("speed0_motors", 32'(bad), 32'd0);

    // Full duty over a 040 run: each drive line drops once per 64 PWM counts.
    TValue1 = 4'd4; TValue0 = 4'd0; Speed = 6'd63; Start = 1'b1;
    cycle();
    nf = int'(MotorFwd); nr = int'(MotorRev);
    Start = 1'b0;
    repeat (159) begin cycle(); nf += int'(MotorFwd); nr += int'(MotorRev); end
    check("pwm_fwd_count", 32'(nf), 32'd55);
    check("pwm_rev_count", 32'(nr), 32'd51);
    cycle();
    check("pwm_run_done", 32'(Done), 32'd1);

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_init();
      end else begin
        Start   = ($urandom_range(0, 11) == 0);
        Pause   = ($urandom_range(0, 7) == 0);
        TValue0 = 4'($urandom_range(0, 15));
        TValue1 = 4'($urandom_range(0, 2));
        TValue2 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        Speed   = 6'($urandom_range(0, 63));
        cycle();
        check("excl_motors", 32'(MotorFwd & MotorRev), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
